// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared definitions for the display scheduler slice.
//   DIGIT_OFF            : nibble code that the BCD_to_7seg table renders as
//                          all segments off.
//   PRIMER..CUARTO       : digit index constants, rightmost (0) to leftmost (3).
//   disp_state_e         : overlay arbitration states.
//   blank_leading_zeros  : replaces leading zero nibbles with DIGIT_OFF,
//                          never touching the rightmost digit.
// -----------------------------------------------------------------------------
package display_pkg;

    localparam logic [3:0] DIGIT_OFF = 4'hF;

    localparam int PRIMER  = 0;
    localparam int SEGUNDO = 1;
    localparam int TERCER  = 2;
    localparam int CUARTO  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        HOLD  = 2'd2
    } disp_state_e;

    // Scan from the leftmost digit downward; once a nonzero nibble has been
    // seen, all lower digits are shown as they are. PRIMER is excluded so an
    // all-zero value still shows a single 0.
    function automatic logic [15:0] blank_leading_zeros(input logic [15:0] d);
        logic [15:0] r;
        logic        lead;
        r    = d;
        lead = 1'b1;
        for (int k = CUARTO; k > PRIMER; k--) begin
            if (lead && (d[k*4 +: 4] == 4'h0)) begin
                r[k*4 +: 4] = DIGIT_OFF;
            end else begin
                lead = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/display_scheduler_tick_divider.sv
// -----------------------------------------------------------------------------
// tick_divider
// Counts enabled cycles 0..DIV-1 and wraps. tick_o is high for the enabled
// cycle in which the count equals DIV-1, i.e. once every DIV enabled cycles.
// Ports:
//   clk_i    in  system clock
//   rst_n_i  in  synchronous reset, active-low (count returns to 0)
//   en_i     in  count enable
//   tick_o   out one-cycle pulse on the enabled cycle that wraps the count
// -----------------------------------------------------------------------------
module tick_divider #(
    parameter int DIV = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic en_i,
    output logic tick_o
);

    // DIV = 1 would give a zero-width counter; keep one bit that stays 0.
    localparam int              CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == LAST);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_cnt <= '0;
        end else if (en_i) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

    assign tick_o = en_i & w_last;

endmodule

// File: rtl/display_scheduler.sv
// -----------------------------------------------------------------------------
// display_scheduler
// Shares the 4-digit multiplexed 7-segment driver between a continuous base
// value and a transient overlay value. Generates the multiplexer scan tick,
// arbitrates the overlay with a req/ack handshake and a hold timer, blanks
// leading zeros and blinks selected digits of the base value.
//
// Handshake: ovl_req_i is a level. While the FSM is in IDLE or HOLD and
// ovl_ack_o is low, a high ovl_req_i is accepted on the next clock edge and
// ovl_digits_i is captured on that same edge. ovl_ack_o is then high for
// exactly one cycle (LATCH). The requester drops ovl_req_i once it sees ack;
// a request left high is re-accepted on alternate cycles, which behaves as a
// continuous retrigger.
//
// Ports:
//   clk_i           in  system clock
//   rst_n_i         in  synchronous reset, active-low
//   base_digits_i   in  base value, [3:0]=primer (rightmost) .. [15:12]=cuarto
//   blank_lz_i      in  blank leading zeros of the base value
//   blink_mask_i    in  per-digit blink enable (bit k = digit k), base only
//   ovl_req_i       in  overlay request level
//   ovl_digits_i    in  overlay value, captured on acceptance
//   ovl_ack_o       out one-cycle acceptance pulse
//   scan_tick_o     out one-cycle pulse every SCAN_DIV cycles
//   src_o           out 0 = base owns display, 1 = overlay owns display
//   primer_disp_o .. cuarto_disp_o  out  registered digit codes
//   dbg_state_o     out current arbitration state (disp_state_e encoding)
// -----------------------------------------------------------------------------
module display_scheduler
    import display_pkg::*;
#(
    parameter int SCAN_DIV   = 50000,
    parameter int BLINK_DIV  = 250,
    parameter int HOLD_TICKS = 2000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [15:0] base_digits_i,
    input  logic        blank_lz_i,
    input  logic [3:0]  blink_mask_i,
    input  logic        ovl_req_i,
    input  logic [15:0] ovl_digits_i,
    output logic        ovl_ack_o,
    output logic        scan_tick_o,
    output logic        src_o,
    output logic [3:0]  primer_disp_o,
    output logic [3:0]  segundo_disp_o,
    output logic [3:0]  tercer_disp_o,
    output logic [3:0]  cuarto_disp_o,
    output logic [1:0]  dbg_state_o
);

    // The hold counter must represent HOLD_TICKS itself.
    localparam int            HW        = $clog2(HOLD_TICKS + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_TICKS);
    localparam logic [HW-1:0] HOLD_LAST = HW'(1);

    logic          w_scan_tick;
    logic          w_blink_tick;
    logic          r_blink_phase;

    disp_state_e   r_state;
    disp_state_e   w_state_nxt;
    logic [HW-1:0] r_hold;
    logic [HW-1:0] w_hold_nxt;
    logic          w_latch_en;
    logic [15:0]   r_latch;

    logic          w_ack;
    logic          w_src;
    logic          w_accept;
    logic [15:0]   w_digits;
    logic [15:0]   r_digits;

    // ------------------------------------------------------------------
    // Scan prescaler and blink divider
    // ------------------------------------------------------------------
    tick_divider #(
        .DIV (SCAN_DIV)
    ) u_prescaler (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (1'b1),
        .tick_o  (w_scan_tick)
    );

    tick_divider #(
        .DIV (BLINK_DIV)
    ) u_blink (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (w_scan_tick),
        .tick_o  (w_blink_tick)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_blink_phase <= 1'b0;
        end else if (w_blink_tick) begin
            r_blink_phase <= ~r_blink_phase;
        end
    end

    // ------------------------------------------------------------------
    // Overlay arbitration FSM
    // ------------------------------------------------------------------
    assign w_ack    = (r_state == LATCH);
    assign w_src    = (r_state != IDLE);
    assign w_accept = ovl_req_i & ~w_ack;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
            r_hold  <= '0;
            r_latch <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
            if (w_latch_en) begin
                r_latch <= ovl_digits_i;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_latch_en  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = LATCH;
                    w_latch_en  = 1'b1;
                end
            end
            LATCH: begin
                w_state_nxt = HOLD;
                w_hold_nxt  = HOLD_LOAD;
            end
            HOLD: begin
                // A new request beats an expiring hold on the same edge.
                if (w_accept) begin
                    w_state_nxt = LATCH;
                    w_latch_en  = 1'b1;
                end else if (w_scan_tick) begin
                    w_hold_nxt = r_hold - 1'b1;
                    if (r_hold == HOLD_LAST) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Digit composition; the overlay is shown exactly as captured.
    // ------------------------------------------------------------------
    always_comb begin
        w_digits = r_latch;
        if (!w_src) begin
            w_digits = blank_lz_i ? blank_leading_zeros(base_digits_i)
                                  : base_digits_i;
            for (int k = PRIMER; k <= CUARTO; k++) begin
                if (blink_mask_i[k] && r_blink_phase) begin
                    w_digits[k*4 +: 4] = DIGIT_OFF;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_digits <= {4{DIGIT_OFF}};
        end else begin
            r_digits <= w_digits;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ovl_ack_o      = w_ack;
    assign src_o          = w_src;
    assign scan_tick_o    = w_scan_tick;
    assign dbg_state_o    = r_state;
    assign primer_disp_o  = r_digits[PRIMER*4  +: 4];
    assign segundo_disp_o = r_digits[SEGUNDO*4 +: 4];
    assign tercer_disp_o  = r_digits[TERCER*4  +: 4];
    assign cuarto_disp_o  = r_digits[CUARTO*4  +: 4];

endmodule

// File: tb/tb_display_scheduler.sv
module tb_display_scheduler;
  import display_pkg::*;

  localparam int S = 4;   // SCAN_DIV
  localparam int B = 2;   // BLINK_DIV
  localparam int H = 3;   // HOLD_TICKS

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] base_digits;
  logic        blank_lz;
  logic [3:0]  blink_mask;
  logic        ovl_req;
  logic [15:0] ovl_digits;
  logic        ovl_ack_o;
  logic        scan_tick_o;
  logic        src_o;
  logic [3:0]  primer_disp_o, segundo_disp_o, tercer_disp_o, cuarto_disp_o;
  logic [1:0]  dbg_state_o;
  logic [15:0] dut_digits;

  always #5 clk = ~clk;

  assign dut_digits = {cuarto_disp_o, tercer_disp_o, segundo_disp_o, primer_disp_o};

  display_scheduler #(
    .SCAN_DIV   (S),
    .BLINK_DIV  (B),
    .HOLD_TICKS (H)
  ) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .base_digits_i  (base_digits),
    .blank_lz_i     (blank_lz),
    .blink_mask_i   (blink_mask),
    .ovl_req_i      (ovl_req),
    .ovl_digits_i   (ovl_digits),
    .ovl_ack_o      (ovl_ack_o),
    .scan_tick_o    (scan_tick_o),
    .src_o          (src_o),
    .primer_disp_o  (primer_disp_o),
    .segundo_disp_o (segundo_disp_o),
    .tercer_disp_o  (tercer_disp_o),
    .cuarto_disp_o  (cuarto_disp_o),
    .dbg_state_o    (dbg_state_o)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] exp_q[$];

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  // m_cyc   : clock edges since the last reset edge
  // m_ticks : scan ticks completed since reset
  // m_mode  : 0 base shown, 1 acceptance cycle, 2 overlay shown
  // m_left  : scan ticks the overlay still has to stay
  int          m_cyc   = 0;
  int          m_ticks = 0;
  int          m_mode  = 0;
  int          m_left  = 0;
  logic [15:0] m_ovl   = 16'h0;

  function automatic logic [15:0] model_digits(input logic ovl_src, input logic [15:0] ovl,
                                               input logic [15:0] base, input logic blz,
                                               input logic [3:0] mask, input logic ph);
    logic [15:0] d;
    logic        leading;
    if (ovl_src) return ovl;
    d = base;
    leading = blz;
    for (int k = 3; k >= 1; k--) begin
      if (leading && d[k*4 +: 4] == 4'h0) d[k*4 +: 4] = 4'hF;
      else leading = 1'b0;
    end
    for (int k = 0; k < 4; k++)
      if (mask[k] && ph) d[k*4 +: 4] = 4'hF;
    return d;
  endfunction

  // ---------------- driver tasks ----------------
  // Advance one clock with the inputs currently driven, then check all outputs.
  task automatic step();
    logic        tick_now;
    logic        ph;
    logic [1:0]  exp_state;
    logic [15:0] exp_d;
    tick_now = ((m_cyc % S) == S - 1);
    ph       = (((m_ticks / B) % 2) == 1);
    if (!rst_n) exp_d = 16'hFFFF;
    else        exp_d = model_digits(m_mode != 0, m_ovl, base_digits, blank_lz, blink_mask, ph);
    exp_q.push_back(exp_d);
    if (!rst_n) begin
      m_cyc = 0; m_ticks = 0; m_mode = 0; m_left = 0; m_ovl = 16'h0;
    end else begin
      if (ovl_req && m_mode != 1) begin
        m_mode = 1;
        m_ovl  = ovl_digits;
      end else if (m_mode == 1) begin
        m_mode = 2;
        m_left = H;
      end else if (m_mode == 2 && tick_now) begin
        m_left--;
        if (m_left == 0) m_mode = 0;
      end
      if (tick_now) m_ticks++;
      m_cyc++;
    end
    exp_state = (m_mode == 0) ? IDLE : (m_mode == 1) ? LATCH : HOLD;
    @(posedge clk);
    #1;
    check_val("digits", dut_digits, exp_q.pop_front());
    check_val("scan_tick", 16'(scan_tick_o), 16'((m_cyc % S) == S - 1));
    check_val("ack", 16'(ovl_ack_o), 16'(m_mode == 1));
    check_val("src", 16'(src_o), 16'(m_mode != 0));
    check_val("state", 16'(dbg_state_o), 16'(exp_state));
  endtask

  task automatic req_until_ack(input logic [15:0] v, output logic got);
    ovl_req    = 1'b1;
    ovl_digits = v;
    got        = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      if (ovl_ack_o === 1'b1) got = 1'b1;
    end
    ovl_req = 1'b0;
  endtask

  // Count scan ticks seen while the overlay is holding, until src drops.
  task automatic count_hold_ticks(output int n);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      if (src_o === 1'b1 && ovl_ack_o === 1'b0 && scan_tick_o === 1'b1) n++;
      if (src_o === 1'b0) break;
      step();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic        got;
    int          n1, n2, n_f, n_4, n_hi;
    logic [15:0] v;

    rst_n = 1'b0; base_digits = 16'h0042; blank_lz = 1'b1; blink_mask = 4'h0;
    ovl_req = 1'b0; ovl_digits = 16'h0;

    // 1. reset and scan tick cadence
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("rst_digits", dut_digits, 16'hFFFF);
    end
    rst_n = 1'b1;
    for (int c = 2; c <= 13; c++) begin
      step();
      check_val("tick_cadence", 16'(scan_tick_o), 16'((c % 4) == 0));
    end

    // 2. leading zero blanking
    base_digits = 16'h0042; blank_lz = 1'b1; step();
    check_val("blank_0042", dut_digits, 16'hFF42);
    base_digits = 16'h0000; step();
    check_val("blank_0000", dut_digits, 16'hFFF0);
    base_digits = 16'h0042; blank_lz = 1'b0; step();
    check_val("noblank_0042", dut_digits, 16'h0042);
    blank_lz = 1'b1; step();

    // 3. single overlay
    req_until_ack(16'h0012, got);
    check_val("ack_seen_1", 16'(got), 16'd1);
    step();
    check_val("ack_one_cycle", 16'(ovl_ack_o), 16'd0);
    check_val("ovl_shown", dut_digits, 16'h0012);
    count_hold_ticks(n1);
    check_val("hold_ticks", 16'(n1), 16'(H));
    check_val("src_released", 16'(src_o), 16'd0);
    step();
    check_val("base_back", dut_digits, 16'hFF42);

    // 4. retrigger after two scan ticks
    req_until_ack(16'h0012, got);
    check_val("ack_seen_2", 16'(got), 16'd1);
    n1 = 0;
    for (int i = 0; i < 40 && n1 < 2; i++) begin
      step();
      if (src_o === 1'b1 && ovl_ack_o === 1'b0 && scan_tick_o === 1'b1) n1++;
    end
    req_until_ack(16'h5678, got);
    check_val("ack_seen_retrig", 16'(got), 16'd1);
    step();
    check_val("retrig_shown", dut_digits, 16'h5678);
    count_hold_ticks(n2);
    check_val("retrig_total_ticks", 16'(n1 + n2), 16'd5);
    step();

    // 5. blinking primer
    blank_lz = 1'b0; base_digits = 16'h1234; blink_mask = 4'b0001;
    step();
    n_f = 0; n_4 = 0; n_hi = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (primer_disp_o === 4'hF) n_f++;
      if (primer_disp_o === 4'h4) n_4++;
      if (dut_digits[15:4] === 12'h123) n_hi++;
    end
    check_val("blink_off_cycles", 16'(n_f), 16'd8);
    check_val("blink_on_cycles", 16'(n_4), 16'd8);
    check_val("blink_steady", 16'(n_hi), 16'd16);
    blink_mask = 4'hF;
    req_until_ack(16'h0000, got);
    check_val("ack_seen_mask", 16'(got), 16'd1);
    for (int i = 0; i < 6; i++) begin
      step();
      check_val("ovl_no_blink", dut_digits, 16'h0000);
    end
    count_hold_ticks(n2);
    blink_mask = 4'h0;
    step(); step();

    // 6. reset in the middle of a hold
    req_until_ack(16'h4321, got);
    step(); step();
    rst_n = 1'b0; step();
    check_val("midrst_state", 16'(dbg_state_o), 16'(IDLE));
    check_val("midrst_src", 16'(src_o), 16'd0);
    check_val("midrst_ack", 16'(ovl_ack_o), 16'd0);
    check_val("midrst_digits", dut_digits, 16'hFFFF);
    rst_n = 1'b1; step();
    req_until_ack(16'hABCD, got);
    check_val("ack_after_rst", 16'(got), 16'd1);
    step();
    check_val("ovl_after_rst", dut_digits, 16'hABCD);

    // 7. randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      v = 16'h0;
      for (int k = 0; k < 4; k++)
        v[k*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      base_digits = v;
      if ($urandom_range(0, 7) == 0) blank_lz = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) blink_mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) ovl_req = ~ovl_req;
      ovl_digits = 16'($urandom);
      rst_n = ($urandom_range(0, 299) != 0);
      step();
    end
    rst_n = 1'b1;
    ovl_req = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
